// File: rtl/det_share_sched.sv
`timescale 1ns/1ps
// Round-robin arbiter that time-shares one serial 1011 detector among N word requesters,
// shifting each granted word MSB-first and returning its hit count tagged with the requester id.
module det_share_sched #(
    parameter int unsigned N       = 4,
    parameter int unsigned W       = 8,
    parameter int unsigned DET_LAT = 1,
    parameter int unsigned IW      = $clog2(N),
    parameter int unsigned CW      = $clog2(W + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req_valid,
    input  logic [N*W-1:0]  req_data,
    output logic [N-1:0]    req_ready,
    output logic            det_rstn,
    output logic            det_in,
    input  logic            det_out,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [IW-1:0]   res_id,
    output logic [CW-1:0]   res_count,
    output logic            res_hit,
    output logic            busy
);
    localparam int unsigned KMAX = (W > DET_LAT) ? W : DET_LAT;
    localparam int unsigned KW   = $clog2(KMAX + 1);

    typedef enum logic [2:0] {IDLE, CLR, SHIFT, DRAIN, RESP} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   grant;
    logic            grant_vld;
    logic [IW-1:0]   id_q;
    logic [W-1:0]    sh_q;
    logic [KW-1:0]   step_q;
    logic [CW-1:0]   hit_q;
    logic            last_bit;
    logic            drain_done;
    logic            sample;

    // First asserted request at or after rr_ptr, wrapping modulo N.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!grant_vld && req_valid[IW'(rr_ptr + IW'(i))]) begin
                grant     = IW'(rr_ptr + IW'(i));
                grant_vld = 1'b1;
            end
        end
    end

    assign last_bit   = (step_q == KW'(W - 1));
    assign drain_done = (step_q == KW'(DET_LAT - 1));
    // det_out lags det_in by DET_LAT, so the first DET_LAT shift cycles see stale output.
    assign sample     = det_out && (((state == SHIFT) && (step_q >= KW'(DET_LAT))) || (state == DRAIN));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_vld) state_nxt = CLR;
            CLR:     state_nxt = SHIFT;
            SHIFT:   if (last_bit) state_nxt = DRAIN;
            DRAIN:   if (drain_done) state_nxt = RESP;
            RESP:    if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        det_rstn  = 1'b1;
        det_in    = 1'b0;
        res_valid = 1'b0;
        res_id    = '0;
        res_count = '0;
        res_hit   = 1'b0;
        busy      = 1'b0;
        if (rst) begin
            det_rstn = 1'b0;
        end else begin
            busy = (state != IDLE);
            case (state)
                IDLE:  if (grant_vld) req_ready = N'(1) << grant;
                CLR:   det_rstn = 1'b0;
                SHIFT: det_in = sh_q[W-1];
                RESP: begin
                    res_valid = 1'b1;
                    res_id    = id_q;
                    res_count = hit_q;
                    res_hit   = |hit_q;
                end
                default: ;
            endcase
        end
    end

    // Word capture, bit sequencing and hit accumulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
            id_q   <= '0;
            sh_q   <= '0;
            step_q <= '0;
            hit_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        rr_ptr <= IW'(grant + IW'(1));
                        id_q   <= grant;
                        sh_q   <= req_data[32'(grant)*W +: W];
                    end
                end
                CLR: begin
                    hit_q  <= '0;
                    step_q <= '0;
                end
                SHIFT: begin
                    sh_q   <= {sh_q[W-2:0], 1'b0};
                    step_q <= last_bit ? '0 : KW'(step_q + KW'(1));
                end
                DRAIN:   step_q <= KW'(step_q + KW'(1));
                default: ;
            endcase
            if (sample) hit_q <= CW'(hit_q + CW'(1));
        end
    end
endmodule

// File: tb/tb_det_share_sched.sv
`timescale 1ns/1ps
// Directed bench for det_share_sched with a behavioural overlapping 1011 Moore detector attached.
module tb_det_share_sched;
    localparam int unsigned N  = 4;
    localparam int unsigned W  = 8;
    localparam int unsigned IW = 2;
    localparam int unsigned CW = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           det_rstn;
    logic           det_in;
    logic           det_out;
    logic           res_valid;
    logic           res_ready;
    logic [IW-1:0]  res_id;
    logic [CW-1:0]  res_count;
    logic           res_hit;
    logic           busy;

    int n_checks = 0;
    int n_pass   = 0;

    det_share_sched #(.N(N), .W(W), .DET_LAT(1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .det_rstn(det_rstn), .det_in(det_in), .det_out(det_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
        .res_count(res_count), .res_hit(res_hit), .busy(busy)
    );

    always #5 clk = ~clk;

    // Detector: states none, 1, 10, 101, 1011; output registered-state Moore, overlapping.
    logic [2:0] ds;
    always_ff @(posedge clk) begin
        if (!det_rstn) ds <= 3'd0;
        else begin
            case (ds)
                3'd0:    ds <= det_in ? 3'd1 : 3'd0;
                3'd1:    ds <= det_in ? 3'd1 : 3'd2;
                3'd2:    ds <= det_in ? 3'd3 : 3'd0;
                3'd3:    ds <= det_in ? 3'd4 : 3'd2;
                default: ds <= det_in ? 3'd1 : 3'd2;
            endcase
        end
    end
    assign det_out = (ds == 3'd4);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int r, input logic [W-1:0] w);
        req_valid[r]       = 1'b1;
        req_data[r*W +: W] = w;
    endtask

    // Runs one word from accept in IDLE to the cycle after the result handshake.
    task automatic run_word(input int g, input logic [W-1:0] w, input int cnt,
                            input int hold, input bit clear);
        logic [W-1:0] seq;
        bit bad;
        seq = '0;
        bad = 1'b0;
        res_ready = (hold == 0);
        #1;
        check("idle_busy", 32'(busy), 32'(0));
        check("grant", 32'(req_ready), 32'(1) << g);
        step();
        if (clear) req_valid[g] = 1'b0;
        check("clr_det_rstn", 32'(det_rstn), 32'(0));
        check("clr_det_in", 32'(det_in), 32'(0));
        check("clr_no_ready", 32'(req_ready), 32'(0));
        for (int k = 0; k < int'(W); k++) begin
            step();
            seq = {seq[W-2:0], det_in};
            if (!det_rstn || res_valid || !busy || (req_ready != '0)) bad = 1'b1;
        end
        check("det_in_seq", 32'(seq), 32'(w));
        check("shift_ctrl_bad", 32'(bad), 32'(0));
        step();
        check("drain_out", {30'd0, det_in, res_valid}, 32'(0));
        step();
        check("res_valid", 32'(res_valid), 32'(1));
        check("res_id", 32'(res_id), 32'(g));
        check("res_count", 32'(res_count), 32'(cnt));
        check("res_hit", 32'(res_hit), 32'(cnt != 0));
        for (int h = 0; h < hold; h++) begin
            step();
            check("hold_valid", 32'(res_valid), 32'(1));
            check("hold_count", 32'(res_count), 32'(cnt));
        end
        res_ready = 1'b1;
        step();
        check("back_idle", 32'(busy), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        logic [W-1:0] words [N];
        int cnts [N];
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        res_ready = 1'b1;
        step();
        step();
        req_valid = '1;
        #1;
        check("rst_req_ready", 32'(req_ready), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_det_rstn", 32'(det_rstn), 32'(0));
        check("rst_res_valid", 32'(res_valid), 32'(0));
        check("rst_det_in", 32'(det_in), 32'(0));
        req_valid = '0;
        rst = 1'b0;
        step();
        check("idle_det_rstn", 32'(det_rstn), 32'(1));

        put(0, 8'b1011_0110); run_word(0, 8'b1011_0110, 2, 0, 1'b1);
        put(2, 8'hFF);        run_word(2, 8'hFF, 0, 0, 1'b1);
        put(1, 8'b0101_1000); run_word(1, 8'b0101_1000, 1, 5, 1'b1);
        put(3, 8'b0000_0101); run_word(3, 8'b0000_0101, 0, 0, 1'b1);
        put(3, 8'b1100_0000); run_word(3, 8'b1100_0000, 0, 0, 1'b1);

        // Reset in the middle of shifting (k=4); rr_ptr was 0 so req1 wins.
        put(1, 8'b1011_0110);
        #1;
        check("pre_rst_grant", 32'(req_ready), 32'b0010);
        step();
        req_valid = '0;
        repeat (5) step();
        rst = 1'b1;
        #1;
        check("mid_rst_det_rstn", 32'(det_rstn), 32'(0));
        step();
        check("mid_rst_busy", 32'(busy), 32'(0));
        check("mid_rst_res_valid", 32'(res_valid), 32'(0));
        check("mid_rst_det_rstn2", 32'(det_rstn), 32'(0));
        rst = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            step();
            if (res_valid || busy) seen = 1'b1;
        end
        check("no_stale_result", 32'(seen), 32'(0));

        // All requesters active: rr_ptr restarted at 0, so order 0,1,2,3,0.
        words[0] = 8'b1011_0110; cnts[0] = 2;
        words[1] = 8'b0101_1000; cnts[1] = 1;
        words[2] = 8'hFF;        cnts[2] = 0;
        words[3] = 8'b0000_1011; cnts[3] = 1;
        for (int r = 0; r < int'(N); r++) req_data[r*W +: W] = words[r];
        req_valid = '1;
        for (int j = 0; j < 5; j++) run_word(j % 4, words[j % 4], cnts[j % 4], 0, 1'b0);
        req_valid = '0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
